// File: rtl/seq_normalizer_pkg.sv
// Shared types and constants for the sequential normalizer.
package seq_normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/seq_normalizer_norm_detect.sv
// Combinational normalized-condition check: MSB set (unsigned) or
// top two bits differing (signed).
module norm_detect #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             signed_mode,
  output logic             normalized
);

  assign normalized = signed_mode ? (value[WIDTH-1] ^ value[WIDTH-2]) : value[WIDTH-1];

endmodule

// File: rtl/seq_normalizer.sv
// Iterative left-shift normalizer, one shift per clock.
// Signed normalization is built only when SEQ_NORMALIZER_SIGNED_EN is defined.
//
// state | meaning
// IDLE  | waiting for start_i, results held
// SHIFT | test normalized condition, shift left by one if not yet met
// DONE  | one-cycle done_o pulse, results valid
module seq_normalizer
  import seq_normalizer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     signed_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(WIDTH)-1:0] shift_count_o,
  output logic                     zero_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [CW-1:0]    count_q;
  logic             zero_q;
  logic             signed_mode;
  logic             normalized;
  logic             finish;

`ifdef SEQ_NORMALIZER_SIGNED_EN
  logic signed_mode_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      signed_mode_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      signed_mode_q <= signed_i;
    end
  end

  assign signed_mode = signed_mode_q;
`else
  logic signed_unused;

  assign signed_unused = signed_i;
  assign signed_mode   = 1'b0;
`endif

  norm_detect #(.WIDTH(WIDTH)) u_norm_detect (
    .value       (work_q),
    .signed_mode (signed_mode),
    .normalized  (normalized)
  );

  // Count saturation also terminates the all-zero / all-ones cases.
  assign finish = normalized || (count_q == COUNT_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   if (finish) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      work_q        <= '0;
      count_q       <= '0;
      zero_q        <= 1'b0;
      data_o        <= '0;
      shift_count_o <= '0;
      zero_o        <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            work_q  <= data_i;
            count_q <= '0;
            zero_q  <= (data_i == '0);
          end
        end
        SHIFT: begin
          if (finish) begin
            data_o        <= work_q;
            shift_count_o <= count_q;
            zero_o        <= zero_q;
          end else begin
            work_q  <= {work_q[WIDTH-2:0], 1'b0};
            count_q <= count_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer (WIDTH=32); expectations follow
// SEQ_NORMALIZER_SIGNED_EN when it is defined.
module tb_seq_normalizer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  data_in;
  logic          sgn;
  logic          busy, done;
  logic [W-1:0]  data_out;
  logic [4:0]    shift_cnt;
  logic          zero;

  int n_vec = 0;
  int n_err = 0;

  seq_normalizer #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .data_i        (data_in),
    .signed_i      (sgn),
    .busy_o        (busy),
    .done_o        (done),
    .data_o        (data_out),
    .shift_count_o (shift_cnt),
    .zero_o        (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic        s;
    logic [31:0] exp_data;
    logic [4:0]  exp_cnt;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: count leading zeros (unsigned) or redundant sign bits (signed).
  task automatic ref_model(input logic [31:0] v, input logic s_in,
                           output logic [31:0] rd, output logic [4:0] rc);
    int n;
    int c;
    logic s;
    logic lead;
`ifdef SEQ_NORMALIZER_SIGNED_EN
    s = s_in;
`else
    s = 1'b0 & s_in;
`endif
    lead = s ? v[31] : 1'b0;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i] != lead) break;
      n++;
    end
    c = s ? n - 1 : n;
    if (c > 31) c = 31;
    rc = 5'(c);
    rd = v << c;
  endtask

  task automatic run_op(input logic [31:0] d, input logic s,
                        output logic [31:0] rd, output logic [4:0] rc,
                        output logic rz, output int lat);
    @(negedge clk);
    start = 1'b1; data_in = d; sgn = s;
    @(negedge clk);
    start = 1'b0; data_in = $urandom(); sgn = 1'b0;
    lat = 1;
    check("busy_after_accept", 32'(busy), 32'd1);
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    rd = data_out; rc = shift_cnt; rz = zero;
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, md;
    logic [4:0]  rc, mc;
    logic        rz;
    int          lat, pulses;
    logic [5:0]  mask;
    logic [31:0] v;

    rst = 1'b1; start = 1'b0; data_in = '0; sgn = 1'b0;

    vecs.push_back('{32'h0000_1000, 1'b0, 32'h8000_0000, 5'd19, 1'b0, 21});
    vecs.push_back('{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1, 33});
    vecs.push_back('{32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0, 2});
    vecs.push_back('{32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 33});
    vecs.push_back('{32'h1234_5678, 1'b0, 32'h91A2_B3C0, 5'd3,  1'b0, 5});
    vecs.push_back('{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1, 33});
`ifdef SEQ_NORMALIZER_SIGNED_EN
    vecs.push_back('{32'hFFFF_FF00, 1'b1, 32'h8000_0000, 5'd23, 1'b0, 25});
    vecs.push_back('{32'h0000_00FF, 1'b1, 32'h7F80_0000, 5'd23, 1'b0, 25});
    vecs.push_back('{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b0, 33});
    vecs.push_back('{32'h4000_0000, 1'b1, 32'h4000_0000, 5'd0,  1'b0, 2});
    vecs.push_back('{32'hC000_0000, 1'b1, 32'h8000_0000, 5'd1,  1'b0, 3});
`else
    vecs.push_back('{32'hFFFF_FF00, 1'b1, 32'hFFFF_FF00, 5'd0,  1'b0, 2});
    vecs.push_back('{32'h0000_00FF, 1'b1, 32'hFF00_0000, 5'd24, 1'b0, 26});
    vecs.push_back('{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 5'd0,  1'b0, 2});
    vecs.push_back('{32'h4000_0000, 1'b1, 32'h8000_0000, 5'd1,  1'b0, 3});
    vecs.push_back('{32'hC000_0000, 1'b1, 32'hC000_0000, 5'd0,  1'b0, 2});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_count", 32'(shift_cnt), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].din, vecs[i].s, rd, rc, rz, lat);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      check($sformatf("vec%0d_count", i), 32'(rc), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_zero", i), 32'(rz), 32'(vecs[i].exp_zero));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Start while busy is ignored and not queued
    @(negedge clk);
    start = 1'b1; data_in = 32'h0000_1000; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; rd = '0; rc = '0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 3) begin start = 1'b1; data_in = 32'hFFFF_FFFF; end
      if (c == 4) start = 1'b0;
      if (done === 1'b1) begin pulses++; rd = data_out; rc = shift_cnt; end
      @(negedge clk);
    end
    check("busy_start_pulses", 32'(pulses), 32'd1);
    check("busy_start_data", rd, 32'h8000_0000);
    check("busy_start_count", 32'(rc), 32'd19);

    // Back-to-back: start held high through DONE
    @(negedge clk);
    start = 1'b1; data_in = 32'h8000_0000; sgn = 1'b0;
    @(negedge clk);
    mask = '0;
    for (int c = 1; c <= 5; c++) begin
      mask[c] = done;
      if (c == 5) start = 1'b0;
      else @(negedge clk);
    end
    check("b2b_done_cycles", 32'(mask), 32'b100100);
    repeat (4) @(negedge clk);

    // Reset in the 5th SHIFT cycle aborts without done
    run_op(32'h1234_5678, 1'b0, rd, rc, rz, lat);
    @(negedge clk);
    start = 1'b1; data_in = 32'h0000_0001; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data", data_out, 32'd0);
    check("abort_count", 32'(shift_cnt), 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    pulses = 0;
    for (int c = 0; c < 36; c++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_op(32'h0000_0001, 1'b0, rd, rc, rz, lat);
    check("after_abort_count", 32'(rc), 32'd31);
    check("after_abort_data", rd, 32'h8000_0000);

    // Randomized against the reference model, 100 per mode
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 100; k++) begin
        v = $urandom() >> $urandom_range(0, 31);
        if (m == 1 && $urandom_range(0, 1) == 1) v = ~v;
        ref_model(v, m[0], md, mc);
        run_op(v, m[0], rd, rc, rz, lat);
        check($sformatf("rnd_m%0d_%0h_data", m, v), rd, md);
        check($sformatf("rnd_m%0d_%0h_count", m, v), 32'(rc), 32'(mc));
        check($sformatf("rnd_m%0d_%0h_latency", m, v), 32'(lat), 32'(mc) + 32'd2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
